// File: rtl/fifo_uart_tx.sv
// Pops words from the async FIFO read side and sends each one as a UART frame, LSB first, with optional parity.
// Latency: a word seen in IDLE at edge N gives start bit, busy and r_inc at N+1. Frames run back-to-back without a gap.
// Backpressure: pops only while the FIFO is not empty. Define FIFO_UART_TX_STOP2_EN to send two stop bits.
module fifo_uart_tx #(
    parameter int data_width     = 8,
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      empty,
    input  logic [data_width-1:0]     rd_data,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [prescale_width-1:0] prescale,
    output logic                      r_inc,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int cnt_w = $clog2(data_width + 1);
`ifdef FIFO_UART_TX_STOP2_EN
    localparam int stop_bits = 2;
`else
    localparam int stop_bits = 1;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [prescale_width-1:0] pcnt;
    logic [prescale_width-1:0] p_q;
    logic [prescale_width-1:0] p_eff;
    logic [cnt_w-1:0]          bit_cnt;
    logic [data_width-1:0]     shreg;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      bit_end;
    logic                      last_data;
    logic                      last_stop;
    logic                      capture;

    assign p_eff     = (prescale == '0) ? prescale_width'(1) : prescale;
    assign bit_end   = (pcnt == p_q - prescale_width'(1));
    assign last_data = (bit_cnt == cnt_w'(data_width - 1));
    // bit_cnt also indexes the stop bits, so two stop bits need no extra counter
    assign last_stop = (bit_cnt == cnt_w'(stop_bits - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    capture   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && last_data) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end && last_stop) begin
                    if (!empty) begin
                        capture   = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inc     <= 1'b0;
            pcnt      <= '0;
            p_q       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            r_inc <= capture;

            if (state == IDLE || bit_end) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + prescale_width'(1);
            end

            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (bit_end && (state == DATA || state == STOP)) begin
                bit_cnt <= bit_cnt + cnt_w'(1);
            end

            if (capture) begin
                shreg     <= rd_data;
                p_q       <= p_eff;
                par_en_q  <= par_en;
                par_bit_q <= (^rd_data) ^ par_typ;
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end

    always_comb begin
        tx_out = 1'b1;
        case (state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = shreg[0];
            PARITY:  tx_out = par_bit_q;
            default: tx_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx. A queue stands in for the FIFO and is popped whenever r_inc is seen.
// Outputs are sampled 1ns after each rising edge. Inputs are driven at the same point.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_STOP2_EN
    localparam int sb = 2;
`else
    localparam int sb = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd1;
    logic       r_inc;
    logic       tx_out;
    logic       busy;

    logic [7:0] q[$];
    logic       tx_log[0:255];
    logic       busy_log[0:255];
    logic       rinc_log[0:255];
    int         n_checks = 0;
    int         n_fail = 0;

    fifo_uart_tx #(.data_width(8), .prescale_width(6)) dut (
        .clk(clk), .rst(rst), .empty(empty), .rd_data(rd_data),
        .par_en(par_en), .par_typ(par_typ), .prescale(prescale),
        .r_inc(r_inc), .tx_out(tx_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (r_inc && q.size() > 0) q.delete(0);
        empty   = (q.size() == 0);
        rd_data = empty ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        empty   = 1'b0;
        rd_data = q[0];
    endtask

    task automatic capture(input int n, input int chg_at, input logic [5:0] new_p, input logic new_pe);
        for (int i = 0; i < n; i++) begin
            step();
            tx_log[i]   = tx_out;
            busy_log[i] = busy;
            rinc_log[i] = r_inc;
            if (i == chg_at) begin
                prescale = new_p;
                par_en   = new_pe;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || r_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: tx=%b busy=%b r_inc=%b, need 1 0 0", i, tx_out, busy, r_inc);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || r_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: tx=%b busy=%b r_inc=%b, need 1 0 0", i, tx_out, busy, r_inc);
            end
        end
    endtask

    task automatic test_basic();
        logic [0:13] exp_tx;
        int          nb;
        int          nr;
        exp_tx   = 14'b01010010111111;
        prescale = 6'd1;
        par_en   = 1'b0;
        push(8'hA5);
        capture(14, -1, 6'd0, 1'b0);
        n_checks++;
        if (tx_log[0] !== 1'b0 || busy_log[0] !== 1'b1 || rinc_log[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: tx=%b busy=%b r_inc=%b, need 0 1 1", tx_log[0], busy_log[0], rinc_log[0]);
        end
        n_checks++;
        if (rinc_log[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rinc_width: r_inc=%b at second cycle, need 0", rinc_log[1]);
        end
        nb = 0;
        nr = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy_log[i] === 1'b1) nb++;
            if (rinc_log[i] === 1'b1) nr++;
            n_checks++;
            if (tx_log[i] !== exp_tx[i]) begin
                n_fail++;
                $display("FAIL basic_tx cyc %0d: tx=%b, need %b", i, tx_log[i], exp_tx[i]);
            end
        end
        n_checks++;
        if (nb != 9 + sb || nr != 1) begin
            n_fail++;
            $display("FAIL basic_counts: busy cycles %0d pops %0d, need %0d and 1", nb, nr, 9 + sb);
        end
    endtask

    task automatic test_parity(input logic typ, input logic exp_par);
        int nb;
        int f;
        f        = (10 + sb) * 2;
        prescale = 6'd2;
        par_en   = 1'b1;
        par_typ  = typ;
        push(8'h07);
        capture(f + 4, -1, 6'd0, 1'b0);
        nb = 0;
        for (int i = 0; i < f + 4; i++) if (busy_log[i] === 1'b1) nb++;
        n_checks++;
        if (tx_log[18] !== exp_par || tx_log[19] !== exp_par) begin
            n_fail++;
            $display("FAIL parity_bit typ=%b: got %b%b, need %b%b", typ, tx_log[18], tx_log[19], exp_par, exp_par);
        end
        n_checks++;
        if (tx_log[20] !== 1'b1 || tx_log[17] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_frame typ=%b: d7=%b stop=%b, need 0 1", typ, tx_log[17], tx_log[20]);
        end
        n_checks++;
        if (nb != f) begin
            n_fail++;
            $display("FAIL parity_len typ=%b: busy cycles %0d, need %0d", typ, nb, f);
        end
        par_en  = 1'b0;
        par_typ = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  f;
        logic et;
        f        = (9 + sb) * 4;
        prescale = 6'd4;
        push(8'h00);
        push(8'hFF);
        capture(2 * f + 4, -1, 6'd0, 1'b0);
        for (int i = 0; i < 2 * f + 4; i++) begin
            if (i >= f && i < f + 4) et = 1'b0;
            else if (i < 36)         et = 1'b0;
            else                     et = 1'b1;
            n_checks++;
            if (tx_log[i] !== et || busy_log[i] !== (i < 2 * f) || rinc_log[i] !== (i == 0 || i == f)) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: tx=%b busy=%b r_inc=%b, need %b %b %b",
                         i, tx_log[i], busy_log[i], rinc_log[i], et, (i < 2 * f), (i == 0 || i == f));
            end
        end
    endtask

    task automatic test_settings_change();
        int f1;
        int f2;
        f1       = (9 + sb) * 4;
        f2       = (10 + sb) * 2;
        prescale = 6'd4;
        par_en   = 1'b0;
        push(8'h5A);
        push(8'h3C);
        capture(f1 + f2 + 4, 10, 6'd2, 1'b1);
        n_checks++;
        if (tx_log[32] !== 1'b0 || tx_log[35] !== 1'b0 || tx_log[36] !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_frame1: d7=%b%b stop=%b, need 0 0 1", tx_log[32], tx_log[35], tx_log[36]);
        end
        n_checks++;
        if (rinc_log[f1] !== 1'b1 || rinc_log[f1 - 1] !== 1'b0 || tx_log[f1] !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_second_pop: r_inc=%b prev=%b tx=%b, need 1 0 0", rinc_log[f1], rinc_log[f1 - 1], tx_log[f1]);
        end
        n_checks++;
        if (tx_log[f1 + 18] !== 1'b0 || tx_log[f1 + 19] !== 1'b0 || tx_log[f1 + 20] !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_parity: %b%b stop=%b, need 0 0 1", tx_log[f1 + 18], tx_log[f1 + 19], tx_log[f1 + 20]);
        end
        n_checks++;
        if (busy_log[f1 + f2 - 1] !== 1'b1 || busy_log[f1 + f2] !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_frame2_len: busy end %b then %b, need 1 then 0", busy_log[f1 + f2 - 1], busy_log[f1 + f2]);
        end
        par_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nr;
        prescale = 6'd2;
        push(8'h00);
        capture(9, -1, 6'd0, 1'b0);
        n_checks++;
        if (tx_log[8] !== 1'b0 || busy_log[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: tx=%b busy=%b, need 0 1", tx_log[8], busy_log[8]);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || r_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_line: tx=%b busy=%b r_inc=%b, need 1 0 0", tx_out, busy, r_inc);
        end
        step();
        push(8'h55);
        step();
        n_checks++;
        if (r_inc !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_held: r_inc=%b busy=%b, need 0 0", r_inc, busy);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (r_inc !== 1'b1 || tx_out !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_restart: r_inc=%b tx=%b busy=%b, need 1 0 1", r_inc, tx_out, busy);
        end
        nr = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (r_inc === 1'b1) nr++;
        end
        n_checks++;
        if (nr != 0 || busy !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_after: extra pops %0d busy=%b queued=%0d, need 0 0 0", nr, busy, q.size());
        end
    endtask

    task automatic test_stop_bits();
        int nb;
        prescale = 6'd0;
        par_en   = 1'b0;
        push(8'hA5);
        capture(14, -1, 6'd0, 1'b0);
        nb = 0;
        for (int i = 0; i < 14; i++) if (busy_log[i] === 1'b1) nb++;
        n_checks++;
        if (nb != 9 + sb || busy_log[9 + sb - 1] !== 1'b1 || busy_log[9 + sb] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_len: busy cycles %0d, need %0d", nb, 9 + sb);
        end
        n_checks++;
        if (tx_log[8] !== 1'b1 || tx_log[7] !== 1'b0 || tx_log[9] !== 1'b1 || tx_log[9 + sb - 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_tx: d6=%b d7=%b stop=%b%b, need 0 1 1 1", tx_log[7], tx_log[8], tx_log[9], tx_log[9 + sb - 1]);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_idle: busy=%b tx=%b, need 0 1", busy, tx_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        settle();
        test_parity(1'b0, 1'b1);
        settle();
        test_parity(1'b1, 1'b0);
        settle();
        test_back_to_back();
        settle();
        test_settings_change();
        settle();
        test_reset_mid();
        settle();
        test_stop_bits();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
